// File: rtl/write_rr_scheduler_pkg.sv
// Shared definitions for the write round-robin scheduler and its priority picker.
package write_rr_scheduler_pkg;

    // Width of the selector index that drives the channel selector
    localparam int SEL_W = 4;

    // Scheduler FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Advance a port index by one, wrapping at n ports
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/write_rr_scheduler_rr_priority_pick.sv
// Combinational round-robin picker: first requesting port at or after ptr,
// wrapping modulo num_of_ports. Shared with the read-side scheduler.
module rr_priority_pick
    import write_rr_scheduler_pkg::*;
#(
    parameter int num_of_ports = 16
) (
    input  logic [num_of_ports-1:0] req_i,
    input  logic [SEL_W-1:0]        ptr_i,
    output logic [SEL_W-1:0]        winner_o,
    output logic                    valid_o
);

    int idx;

    // Scan ptr, ptr+1, ... and keep the first port found requesting
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int i = 0; i < num_of_ports; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= num_of_ports) begin
                idx = idx - num_of_ports;
            end
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/write_rr_scheduler.sv
// Round-robin write scheduler: grants one requester per packet and steers the
// channel selector per accepted beat. A grant ends on last beat, on the burst
// cap, or when the owner withdraws its request; one idle cycle always follows.
module write_rr_scheduler
    import write_rr_scheduler_pkg::*;
#(
    parameter int num_of_ports   = 16,
    parameter int max_beats      = 64,
    parameter int beat_cnt_width = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [num_of_ports-1:0]   req_i,
    input  logic [num_of_ports-1:0]   last_i,
    input  logic                      dn_ready_i,
    output logic [num_of_ports-1:0]   grant_o,
    output logic [SEL_W-1:0]          select_o,
    output logic                      sel_enable_o,
    output logic [beat_cnt_width-1:0] beat_cnt_o,
    output logic                      busy_o
);

    localparam logic [beat_cnt_width-1:0] BEAT_CAP = beat_cnt_width'(max_beats);

    logic [0:0]                state_q, state_d;
    logic [num_of_ports-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]          select_q, select_d;
    logic [beat_cnt_width-1:0] beat_cnt_q, beat_cnt_d;
    logic [SEL_W-1:0]          ptr_q, ptr_d;

    logic [SEL_W-1:0]          pick_idx;
    logic                      pick_vld;
    logic                      owner_req;
    logic                      owner_last;
    logic                      beat_acc;
    logic                      end_grant;
    logic [beat_cnt_width-1:0] beat_inc;

    rr_priority_pick #(
        .num_of_ports (num_of_ports)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_vld)
    );

    // Owner-qualified beat acceptance and release conditions; non-owners are ignored
    always_comb begin
        owner_req  = req_i[select_q];
        owner_last = last_i[select_q];
        beat_inc   = beat_cnt_q + 1'b1;
        beat_acc   = (state_q == ST_XFER) && dn_ready_i && owner_req;
        end_grant  = (state_q == ST_XFER) &&
                     (!owner_req || (beat_acc && (owner_last || (beat_inc == BEAT_CAP))));
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in XFER
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        select_d   = select_q;
        beat_cnt_d = beat_cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d           = ST_XFER;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    select_d          = pick_idx;
                    beat_cnt_d        = '0;
                end
            end
            ST_XFER: begin
                if (end_grant) begin
                    // select is kept so the selector input stays stable while idle
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    ptr_d      = wrap_inc(select_q, num_of_ports);
                end else if (beat_acc) begin
                    beat_cnt_d = beat_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            select_q   <= '0;
            beat_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            select_q   <= select_d;
            beat_cnt_q <= beat_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign grant_o      = grant_q;
    assign select_o     = select_q;
    assign sel_enable_o = beat_acc;
    assign beat_cnt_o   = beat_cnt_q;
    assign busy_o       = (state_q == ST_XFER);

endmodule

// File: tb/tb_write_rr_scheduler.sv
// Directed bench for write_rr_scheduler (16 ports, burst cap of 4 beats).
module tb_write_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] last;
    logic        dn_ready;
    logic [15:0] grant;
    logic [3:0]  select;
    logic        sel_enable;
    logic [7:0]  beat_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    typedef struct packed {
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        en;
        logic [7:0]  cnt;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    write_rr_scheduler #(
        .num_of_ports   (16),
        .max_beats      (4),
        .beat_cnt_width (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .last_i       (last),
        .dn_ready_i   (dn_ready),
        .grant_o      (grant),
        .select_o     (select),
        .sel_enable_o (sel_enable),
        .beat_cnt_o   (beat_cnt),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare mid-cycle
    task automatic cyc(input logic [15:0] r, input logic [15:0] l, input logic d,
                       input logic [15:0] eg, input logic [3:0] es, input logic een,
                       input logic [7:0] ec, input logic eb);
        exp_t t;
        exp_t e;
        req      = r;
        last     = l;
        dn_ready = d;
        t.grant  = eg;
        t.sel    = es;
        t.en     = een;
        t.cnt    = ec;
        t.busy   = eb;
        sb.push_back(t);
        @(negedge clk);
        e = sb.pop_front();
        check("grant",      32'(grant),      32'(e.grant));
        check("select",     32'(select),     32'(e.sel));
        check("sel_enable", 32'(sel_enable), 32'(e.en));
        check("beat_cnt",   32'(beat_cnt),   32'(e.cnt));
        check("busy",       32'(busy),       32'(e.busy));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] oh(input int w);
        return 16'(1) << w;
    endfunction

    initial begin
        logic [3:0] prevsel;
        int w;
        rst      = 1'b1;
        req      = '0;
        last     = '0;
        dn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        phase = "reset";
        cyc(16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0, 8'd0, 1'b0);
        check("ptr", 32'(dut.ptr_q), 32'd0);
        rst = 1'b0;

        // Single requester port 3; last on 4th beat coincides with the cap
        phase = "single";
        cyc(16'h0008, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0, 8'd0, 1'b0);
        cyc(16'h0008, 16'h0000, 1'b1, 16'h0008, 4'd3, 1'b1, 8'd0, 1'b1);
        cyc(16'h0008, 16'h0000, 1'b1, 16'h0008, 4'd3, 1'b1, 8'd1, 1'b1);
        cyc(16'h0008, 16'h0000, 1'b1, 16'h0008, 4'd3, 1'b1, 8'd2, 1'b1);
        cyc(16'h0008, 16'h0008, 1'b1, 16'h0008, 4'd3, 1'b1, 8'd3, 1'b1);
        check("ptr", 32'(dut.ptr_q), 32'd4);
        cyc(16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd3, 1'b0, 8'd0, 1'b0);

        // All ports requesting 1-beat packets: rotation with one idle bubble
        phase = "rotate";
        prevsel = 4'd3;
        for (int k = 0; k < 17; k++) begin
            w = (4 + k) % 16;
            cyc(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, prevsel, 1'b0, 8'd0, 1'b0);
            cyc(16'hFFFF, 16'hFFFF, 1'b1, oh(w), 4'(w), 1'b1, 8'd0, 1'b1);
            prevsel = 4'(w);
        end
        check("ptr", 32'(dut.ptr_q), 32'd5);

        // Burst cap on port 5, port 9 served next, then port 5 again
        phase = "cap";
        cyc(16'h0220, 16'h0200, 1'b1, 16'h0000, 4'd4, 1'b0, 8'd0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            cyc(16'h0220, 16'h0200, 1'b1, 16'h0020, 4'd5, 1'b1, 8'(b), 1'b1);
        end
        check("ptr", 32'(dut.ptr_q), 32'd6);
        cyc(16'h0220, 16'h0200, 1'b1, 16'h0000, 4'd5, 1'b0, 8'd0, 1'b0);
        cyc(16'h0220, 16'h0200, 1'b1, 16'h0200, 4'd9, 1'b1, 8'd0, 1'b1);
        cyc(16'h0020, 16'h0020, 1'b1, 16'h0000, 4'd9, 1'b0, 8'd0, 1'b0);
        cyc(16'h0020, 16'h0020, 1'b1, 16'h0020, 4'd5, 1'b1, 8'd0, 1'b1);

        // Backpressure on port 2; port 7 requests meanwhile and is ignored
        phase = "bp";
        cyc(16'h0004, 16'h0000, 1'b1, 16'h0000, 4'd5, 1'b0, 8'd0, 1'b0);
        cyc(16'h0004, 16'h0000, 1'b1, 16'h0004, 4'd2, 1'b1, 8'd0, 1'b1);
        cyc(16'h0084, 16'h0080, 1'b0, 16'h0004, 4'd2, 1'b0, 8'd1, 1'b1);
        cyc(16'h0084, 16'h0080, 1'b0, 16'h0004, 4'd2, 1'b0, 8'd1, 1'b1);
        cyc(16'h0084, 16'h0000, 1'b1, 16'h0004, 4'd2, 1'b1, 8'd1, 1'b1);
        cyc(16'h0084, 16'h0004, 1'b1, 16'h0004, 4'd2, 1'b1, 8'd2, 1'b1);
        check("ptr", 32'(dut.ptr_q), 32'd3);

        // Withdrawal: port 7 drops req after two beats
        phase = "withdraw";
        cyc(16'h0080, 16'h0000, 1'b1, 16'h0000, 4'd2, 1'b0, 8'd0, 1'b0);
        cyc(16'h0080, 16'h0000, 1'b1, 16'h0080, 4'd7, 1'b1, 8'd0, 1'b1);
        cyc(16'h0080, 16'h0000, 1'b1, 16'h0080, 4'd7, 1'b1, 8'd1, 1'b1);
        cyc(16'h0000, 16'h0080, 1'b1, 16'h0080, 4'd7, 1'b0, 8'd2, 1'b1);
        check("ptr", 32'(dut.ptr_q), 32'd8);
        cyc(16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd7, 1'b0, 8'd0, 1'b0);

        // Reset during the third beat of port 12
        phase = "midrst";
        cyc(16'h1001, 16'h0000, 1'b1, 16'h0000, 4'd7, 1'b0, 8'd0, 1'b0);
        cyc(16'h1001, 16'h0000, 1'b1, 16'h1000, 4'd12, 1'b1, 8'd0, 1'b1);
        cyc(16'h1001, 16'h0000, 1'b1, 16'h1000, 4'd12, 1'b1, 8'd1, 1'b1);
        rst = 1'b1;
        cyc(16'h1001, 16'h0000, 1'b1, 16'h1000, 4'd12, 1'b1, 8'd2, 1'b1);
        rst = 1'b0;
        check("ptr", 32'(dut.ptr_q), 32'd0);
        cyc(16'h1001, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0, 8'd0, 1'b0);
        cyc(16'h1001, 16'h0001, 1'b1, 16'h0001, 4'd0, 1'b1, 8'd0, 1'b1);
        cyc(16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0, 8'd0, 1'b0);
        check("ptr", 32'(dut.ptr_q), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
